long_preamble_tx_seq: RTL and testbench

TX framing stage sitting directly downstream of the long-preamble ROM.
- On a start pulse it walks the ROM address 0..PREAMBLE_LEN-1 and emits those I/Q samples on a valid/ready stream.
- It then passes the upstream data-symbol stream through until the last sample.
- Output feeds the DAC/interpolator path.
- It owns the ROM address and the output pipeline register, including backpressure handling.

---
 rtl/ofdm_tx_pkg.sv | 22 ++
 rtl/long_preamble_tx_seq_iq_out_reg.sv | 85 ++++++++
 rtl/long_preamble_tx_seq.sv | 146 ++++++++++++++
 tb/tb_long_preamble_tx_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared definitions for the OFDM TX framing path.
//   - tx_state_e : framing sequencer states (IDLE / PREAMBLE / DATA)
//   - *_DEF      : default preamble length, ROM address width and sample width
//   - iq_sample  : signed I/Q pair at the default sample width
package ofdm_tx_pkg;

  localparam int PREAMBLE_LEN_DEF = 160;
  localparam int ADDR_W_DEF       = 8;
  localparam int DATA_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] i;
    logic signed [DATA_W_DEF-1:0] q;
  } iq_sample;

endpackage

// File: rtl/long_preamble_tx_seq_iq_out_reg.sv
// Single-stage valid/ready output register carrying I, Q, sop and last.
// Ports:
//   clock, reset           : clock, synchronous active-low reset
//   in_valid/in_i/in_q/... : candidate sample offered by the sequencer
//   out_ready              : downstream accepts the held sample
//   load                   : register is empty or being drained this cycle
//   out_i/out_q/out_valid/out_sop/out_last : registered output stream
module iq_out_reg
  import ofdm_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic              in_sop,
  input  logic              in_last,
  input  logic              out_ready,
  output logic              load,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_last
);

  logic [DATA_W-1:0] samp_i_q, samp_i_d;
  logic [DATA_W-1:0] samp_q_q, samp_q_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              last_q, last_d;

  // A new sample may enter whenever the stage is empty or its content leaves now.
  assign load = !valid_q || out_ready;

  // Load/hold rule: hold under backpressure, take a new sample or bubble on load.
  always_comb begin
    samp_i_d = samp_i_q;
    samp_q_d = samp_q_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    last_d   = last_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        samp_i_d = in_i;
        samp_q_d = in_q;
        sop_d    = in_sop;
        last_d   = in_last;
      end else begin
        // Bubble: keep data, but never leave stale framing flags behind.
        sop_d  = 1'b0;
        last_d = 1'b0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Output pipeline register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      samp_i_q <= {DATA_W{1'b0}};
      samp_q_q <= {DATA_W{1'b0}};
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      samp_i_q <= samp_i_d;
      samp_q_q <= samp_q_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      last_q   <= last_d;
    end
  end

  assign out_i     = samp_i_q;
  assign out_q     = samp_q_q;
  assign out_valid = valid_q;
  assign out_sop   = sop_q;
  assign out_last  = last_q;

endmodule

// File: rtl/long_preamble_tx_seq.sv
// TX framing sequencer: on start, walks the long-preamble ROM 0..PREAMBLE_LEN-1
// and streams its I/Q samples, then passes upstream data through until last.
// Ports:
//   clock, reset                 : clock, synchronous active-low reset
//   start                        : frame start pulse (honoured in IDLE only)
//   rom_addr / rom_i / rom_q     : external combinational preamble ROM
//   data_* / data_ready          : upstream data-symbol stream
//   out_* / out_ready            : output stream toward the DAC path
//   busy                         : frame in progress or output still occupied
module long_preamble_tx_seq
  import ofdm_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter bit WINDOW_EN    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_i,
  input  logic [DATA_W-1:0] rom_q,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] data_q,
  input  logic              data_valid,
  input  logic              data_last,
  output logic              data_ready,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PREAMBLE_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              load_s;
  logic              in_valid_s;
  logic [DATA_W-1:0] in_i_s, in_q_s;
  logic              in_sop_s, in_last_s;

  // Sequencer state and ROM address counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter advance and selection of the sample offered to the output stage.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_addr   = {ADDR_W{1'b0}};
    data_ready = 1'b0;
    in_valid_s = 1'b0;
    in_i_s     = rom_i;
    in_q_s     = rom_q;
    in_sop_s   = 1'b0;
    in_last_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PREAMBLE;
          cnt_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        rom_addr   = cnt_q;
        in_valid_s = 1'b1;
        in_sop_s   = (cnt_q == {ADDR_W{1'b0}});
        // Sample 0 is halved to window the symbol boundary; >>> on a signed
        // operand floors toward minus infinity.
        if (WINDOW_EN && (cnt_q == {ADDR_W{1'b0}})) begin
          in_i_s = $signed(rom_i) >>> 1'b1;
          in_q_s = $signed(rom_q) >>> 1'b1;
        end else begin
          in_i_s = rom_i;
          in_q_s = rom_q;
        end
        // The counter only advances when the output stage actually takes the sample,
        // so backpressure never skips or repeats a ROM entry.
        if (load_s) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_DATA;
            cnt_d   = {ADDR_W{1'b0}};
          end else begin
            cnt_d = cnt_q + ADDR_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_DATA: begin
        data_ready = load_s;
        in_valid_s = data_valid;
        in_i_s     = data_i;
        in_q_s     = data_q;
        in_last_s  = data_last;
        if (load_s && data_valid && data_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Outside PREAMBLE/DATA nothing is offered, so a held sample simply drains.
  iq_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid_s),
    .in_i      (in_i_s),
    .in_q      (in_q_s),
    .in_sop    (in_sop_s),
    .in_last   (in_last_s),
    .out_ready (out_ready),
    .load      (load_s),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_last  (out_last)
  );

  assign busy = (state_q != ST_IDLE) || out_valid;

endmodule

// File: tb/tb_long_preamble_tx_seq.sv
// Directed bench for long_preamble_tx_seq with a small preamble ROM model.
module tb_long_preamble_tx_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_i, rom_q;
  logic [15:0] data_i, data_q;
  logic        data_valid, data_last, data_ready;
  logic [15:0] out_i, out_q;
  logic        out_valid, out_ready, out_sop, out_last, busy;

  int errors = 0;
  int checks = 0;

  long_preamble_tx_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_i      (rom_i),
    .rom_q      (rom_q),
    .data_i     (data_i),
    .data_q     (data_q),
    .data_valid (data_valid),
    .data_last  (data_last),
    .data_ready (data_ready),
    .out_i      (out_i),
    .out_q      (out_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_last   (out_last),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM model: anchor entries at 0, 32, 159; a simple pattern elsewhere.
  function automatic logic [15:0] rom_i_f(input int a);
    case (a)
      0:       return 16'h0000;
      32:      return 16'h0000;
      159:     return 16'h0F67;
      default: return 16'(a * 37 + 5);
    endcase
  endfunction

  function automatic logic [15:0] rom_q_f(input int a);
    case (a)
      0:       return 16'hEC00;
      32:      return 16'h1400;
      159:     return 16'hFF58;
      default: return 16'(65535 - a * 11);
    endcase
  endfunction

  // Expected preamble output: sample 0 windowed (0xEC00 >>> 1 = 0xF600).
  function automatic logic [15:0] exp_pre_i(input int n);
    if (n == 0) return 16'h0000;
    return rom_i_f(n);
  endfunction

  function automatic logic [15:0] exp_pre_q(input int n);
    if (n == 0) return 16'hF600;
    return rom_q_f(n);
  endfunction

  assign rom_i = rom_i_f(int'(rom_addr));
  assign rom_q = rom_q_f(int'(rom_addr));

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    data_valid = 1'b1; data_i = 16'h1234; data_q = 16'h5678; data_last = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0 || rom_addr !== 8'h00 ||
          out_i !== 16'h0000 || out_q !== 16'h0000 || out_sop !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c=%0d: got v=%b dr=%b busy=%b addr=%0d i=%h q=%h sop=%b last=%b, want all zero",
                 c, out_valid, data_ready, busy, rom_addr, out_i, out_q, out_sop, out_last);
      end
    end
    data_valid = 1'b0;
  endtask

  // One full frame: preamble then n_data data samples (I=k, Q=-k, last on the final one).
  task automatic run_frame(input bit rnd, input int n_data, input bit poke, input string name);
    int          idx, cyc, dsent, total;
    bit          prev_hold, seen159, fresh;
    logic [15:0] hi, hq, ei, eq;
    logic        esop, elast;
    logic [7:0]  ea;
    total = 160 + n_data;
    idx = 0; dsent = 0; prev_hold = 1'b0; seen159 = 1'b0;
    hi = 16'h0000; hq = 16'h0000;
    @(negedge clock);
    start = 1'b1; out_ready = 1'b1; data_valid = 1'b0; data_last = 1'b0;
    @(negedge clock);
    start = 1'b0; cyc = 1;
    while (idx < total && cyc < 3000) begin
      fresh = 1'b0;
      if (prev_hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_i !== hi || out_q !== hq) begin
          errors++;
          $display("FAIL %s hold idx=%0d: got v=%b i=%h q=%h, want v=1 i=%h q=%h",
                   name, idx, out_valid, out_i, out_q, hi, hq);
        end
      end else if (out_valid === 1'b1) begin
        fresh = 1'b1;
        if (idx < 160) begin
          ei = exp_pre_i(idx); eq = exp_pre_q(idx); esop = (idx == 0); elast = 1'b0;
        end else begin
          ei = 16'(idx - 159); eq = 16'(-(idx - 159)); esop = 1'b0; elast = (idx == total - 1);
        end
        checks++;
        if (out_i !== ei || out_q !== eq || out_sop !== esop || out_last !== elast) begin
          errors++;
          $display("FAIL %s sample idx=%0d: got i=%h q=%h sop=%b last=%b, want i=%h q=%h sop=%b last=%b",
                   name, idx, out_i, out_q, out_sop, out_last, ei, eq, esop, elast);
        end
        if (!rnd) begin
          checks++;
          if (cyc - 2 != idx) begin
            errors++;
            $display("FAIL %s timing idx=%0d: got cycle %0d, want cycle %0d", name, idx, cyc, idx + 2);
          end
        end
        if (idx < 160) begin
          ea = (idx < 159) ? 8'(idx + 1) : 8'h00;
          checks++;
          if (rom_addr !== ea) begin
            errors++;
            $display("FAIL %s rom_addr idx=%0d: got %0d, want %0d", name, idx, rom_addr, ea);
          end
        end
        if (idx == 159) seen159 = 1'b1;
      end
      start      = poke && fresh && (idx == 50 || idx == 160);
      out_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      data_valid = (dsent < n_data) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      data_i     = 16'(dsent + 1);
      data_q     = 16'(-(dsent + 1));
      data_last  = (dsent == n_data - 1);
      #1;
      if (!seen159) begin
        checks++;
        if (data_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s early_ready idx=%0d: got data_ready=%b, want 0", name, idx, data_ready);
        end
      end else if (!rnd && fresh && idx == 159) begin
        checks++;
        if (data_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s first_ready: got data_ready=%b, want 1", name, data_ready);
        end
      end
      if (data_ready === 1'b1 && data_valid) dsent++;
      prev_hold = (out_valid === 1'b1) && !out_ready;
      hi = out_i; hq = out_q;
      if (out_valid === 1'b1 && out_ready) idx++;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; out_ready = 1'b1; data_valid = 1'b0; data_last = 1'b0;
    checks++;
    if (idx != total) begin
      errors++;
      $display("FAIL %s count: got %0d samples, want %0d", name, idx, total);
    end
    for (int w = 0; w < 10; w++) begin
      if (busy === 1'b0) break;
      @(negedge clock);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || rom_addr !== 8'h00 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s drain: got busy=%b v=%b addr=%0d dr=%b, want 0 0 0 0",
               name, busy, out_valid, rom_addr, data_ready);
    end
  endtask

  task automatic test_preamble();      run_frame(1'b0, 2, 1'b0, "preamble");      endtask
  task automatic test_random_ready();  run_frame(1'b1, 3, 1'b0, "random_ready");  endtask
  task automatic test_data();          run_frame(1'b0, 5, 1'b0, "data");          endtask
  task automatic test_start_ignored(); run_frame(1'b0, 2, 1'b1, "start_ignored"); endtask

  task automatic test_reset_mid();
    @(negedge clock);
    start = 1'b1; out_ready = 1'b1; data_valid = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (81) @(negedge clock);
    checks++;
    if (out_valid !== 1'b1 || out_i !== exp_pre_i(80) || out_q !== exp_pre_q(80)) begin
      errors++;
      $display("FAIL reset_mid pre: got v=%b i=%h q=%h, want v=1 i=%h q=%h",
               out_valid, out_i, out_q, exp_pre_i(80), exp_pre_q(80));
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0 || rom_addr !== 8'h00 || busy !== 1'b0 || out_sop !== 1'b0 || out_i !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid post: got v=%b addr=%0d busy=%b sop=%b i=%h, want 0 0 0 0 0000",
               out_valid, rom_addr, busy, out_sop, out_i);
    end
    reset = 1'b1;
    run_frame(1'b0, 2, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_preamble();
    test_random_ready();
    test_data();
    test_start_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
